// File: rtl/rb_serial_tx_pkg.sv
// Shared widths, limits and FSM encoding for the register-bank serial transmitter.
package rb_serial_tx_pkg;

  localparam int FRAME_W = 21;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 18;
  localparam int GAP_CYC = 2;
  localparam int ENTRIES = 8;
  localparam int TIMEOUT = 255;

  localparam int BIT_W = $clog2(FRAME_W);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(ENTRIES - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    GAP,
    WAITD,
    FIN
  } state_t;

  // A frame carries its own bank address ahead of the data so the receiver can place it.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/rb_frame_shifter.sv
// Parallel-in / serial-out frame shifter, MSB first, with an active-low enable
// that is low for exactly FRAME_W cycles after each load.
module rb_frame_shifter
  import rb_serial_tx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] frame_in,
  output logic               sd,
  output logic               sen,
  output logic               last
);

  logic [FRAME_W-1:0] shift_reg;
  logic [BIT_W-1:0]   bit_cnt;
  logic               sen_q;

  // Zeros shift in behind the frame, so the register is empty (sd=0) once the frame is out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      sen_q     <= 1'b1;
    end else if (load) begin
      shift_reg <= frame_in;
      bit_cnt   <= BIT_LAST;
      sen_q     <= 1'b0;
    end else if (shift) begin
      shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
      if (bit_cnt == '0) begin
        sen_q <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  assign sd   = shift_reg[FRAME_W-1];
  assign sen  = sen_q;
  assign last = (bit_cnt == '0);

endmodule

// File: rtl/rb_serial_tx.sv
// Reads all bank entries one at a time and streams each as an address-tagged serial
// frame, then waits for the receiver to acknowledge or times out.
module rb_serial_tx
  import rb_serial_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              RB1_RW,
  output logic [ADDR_W-1:0] RB1_A,
  input  logic [DATA_W-1:0] RB1_Q,
  output logic              sen,
  output logic              sd,
  input  logic              S2_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] next_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              load;
  logic              shift;
  logic              last;
  logic              timeout;

  assign RB1_RW = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    load       = 1'b0;
    shift      = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = FETCH;
          next_idx   = '0;
        end
      end
      FETCH: next_state = LOAD;
      LOAD: begin
        load       = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) begin
          next_state = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (idx == IDX_LAST) begin
            next_state = WAITD;
          end else begin
            next_state = FETCH;
            next_idx   = idx + 1'b1;
          end
        end
      end
      // An acknowledge in the final timeout cycle still counts as success.
      WAITD: begin
        if (S2_done) begin
          next_state = FIN;
        end else if (to_cnt == TO_LAST) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      RB1_A   <= '0;
      gap_cnt <= '0;
      to_cnt  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      idx     <= next_idx;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      to_cnt  <= (state == WAITD) ? to_cnt + 1'b1 : '0;
      busy    <= (next_state != IDLE);
      done    <= (next_state == FIN);
      if (next_state == FETCH) begin
        RB1_A <= next_idx;
      end
      if (state == IDLE && start) begin
        err <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  rb_frame_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .frame_in (make_frame(idx, RB1_Q)),
    .sd       (sd),
    .sen      (sen),
    .last     (last)
  );

endmodule

// File: tb/tb_rb_serial_tx.sv
// Directed bench for rb_serial_tx: a bank model feeds RB1_Q and a negedge receiver
// collects frames, which are compared with hand-computed values.
module tb_rb_serial_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        RB1_RW;
  logic [2:0]  RB1_A;
  logic [17:0] RB1_Q = '0;
  logic        sen;
  logic        sd;
  logic        S2_done;
  logic        busy;
  logic        done;
  logic        err;

  logic [17:0] bank_mem [8];
  logic [20:0] frames [$];
  int          lens [$];
  logic [20:0] rx_word = '0;
  int          rx_bits = 0;
  int          done_count = 0;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int base = 0;
  int done_base = 0;
  int pulse_at = 0;
  bit auto_s2 = 1'b0;
  int lat;

  rb_serial_tx dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .RB1_RW  (RB1_RW),
    .RB1_A   (RB1_A),
    .RB1_Q   (RB1_Q),
    .sen     (sen),
    .sd      (sd),
    .S2_done (S2_done),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Synchronous-read bank: data appears the cycle after the address.
  always @(posedge clk) begin
    if (RB1_RW) RB1_Q <= bank_mem[RB1_A];
  end

  // Receiver: collect bits while sen is low, close the frame when sen rises.
  always @(negedge clk) begin
    if (!sen) begin
      rx_word = {rx_word[19:0], sd};
      rx_bits++;
    end else if (rx_bits != 0) begin
      frames.push_back(rx_word);
      lens.push_back(rx_bits);
      rx_word = '0;
      rx_bits = 0;
    end
    if (done) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    n++;
    start = (n == pulse_at);
    if (auto_s2 && (frames.size() - base >= 8)) S2_done = 1'b1;
  endtask

  task automatic tickUntil(input int target);
    while (n < target) tick();
  endtask

  task automatic applyStimulus();
    base      = frames.size();
    done_base = done_count;
    n         = 1;
    start     = 1'b1;
    tick();
  endtask

  task automatic waitDone(input int limit, output int latency);
    while (!done && n < limit) tick();
    latency = done ? n : 0;
  endtask

  task automatic verifyFrames(input string tag);
    checkOutput({tag, " frame count"}, frames.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < frames.size()) begin
        checkOutput($sformatf("%s len%0d", tag, i), lens[base + i], 21);
        checkOutput($sformatf("%s frame%0d", tag, i), frames[base + i], {i[2:0], bank_mem[i]});
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; S2_done = 1'b0;
    for (int i = 0; i < 8; i++) bank_mem[i] = '0;
    repeat (3) tick();
    checkOutput("reset sen", sen, 1);
    checkOutput("reset sd", sd, 0);
    checkOutput("reset rw", RB1_RW, 1);
    checkOutput("reset addr", RB1_A, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    rst = 1'b1;
    tick(); tick();
    checkOutput("idle busy", busy, 0);

    $display("[TB] all entries 3FFFF");
    for (int i = 0; i < 8; i++) bank_mem[i] = 18'h3FFFF;
    auto_s2 = 1'b1; S2_done = 1'b0;
    applyStimulus();
    checkOutput("t1 busy", busy, 1);
    waitDone(300, lat);
    checkOutput("t1 latency", lat, 203);
    checkOutput("t1 busy in fin", busy, 1);
    tick();
    checkOutput("t1 busy after", busy, 0);
    checkOutput("t1 done pulse", done, 0);
    tick();
    verifyFrames("t1");
    checkOutput("t1 done count", done_count - done_base, 1);
    checkOutput("t1 err", err, 0);

    $display("[TB] single pattern in entry 5");
    auto_s2 = 1'b0; S2_done = 1'b0;
    for (int i = 0; i < 8; i++) bank_mem[i] = '0;
    bank_mem[5] = 18'h2A5A5;
    auto_s2 = 1'b1;
    applyStimulus();
    waitDone(300, lat);
    checkOutput("t2 latency", lat, 203);
    tick(); tick();
    verifyFrames("t2");
    if (base + 5 < frames.size())
      checkOutput("t2 frame5 bits", frames[base + 5], 21'b101_101010010110100101);

    $display("[TB] receiver never acknowledges");
    auto_s2 = 1'b0; S2_done = 1'b0;
    applyStimulus();
    tickUntil(457);
    checkOutput("t3 err before", err, 0);
    checkOutput("t3 busy before", busy, 1);
    tick();
    checkOutput("t3 err at timeout", err, 1);
    checkOutput("t3 busy at timeout", busy, 0);
    tick(); tick();
    checkOutput("t3 err sticky", err, 1);
    checkOutput("t3 no done", done_count - done_base, 0);
    checkOutput("t3 frame count", frames.size() - base, 8);

    $display("[TB] start repeated mid-transfer and in FIN");
    for (int i = 0; i < 8; i++) bank_mem[i] = 18'h15000 + 18'(i);
    pulse_at = 60; auto_s2 = 1'b1;
    applyStimulus();
    checkOutput("t4 err cleared", err, 0);
    waitDone(300, lat);
    checkOutput("t4 latency", lat, 203);
    start = 1'b1;
    tick();
    checkOutput("t4 fin start busy", busy, 0);
    tick();
    checkOutput("t4 fin start busy2", busy, 0);
    pulse_at = 0;
    verifyFrames("t4");
    checkOutput("t4 done count", done_count - done_base, 1);

    $display("[TB] reset in the middle of frame 2");
    auto_s2 = 1'b0; S2_done = 1'b0;
    for (int i = 0; i < 8; i++) bank_mem[i] = 18'h00F00 | 18'(i * 3);
    auto_s2 = 1'b1;
    applyStimulus();
    tickUntil(39);
    checkOutput("t5 sen mid frame", sen, 0);
    checkOutput("t5 addr mid frame", RB1_A, 1);
    rst = 1'b0;
    #1;
    checkOutput("t5 sen on reset", sen, 1);
    checkOutput("t5 sd on reset", sd, 0);
    checkOutput("t5 busy on reset", busy, 0);
    checkOutput("t5 addr on reset", RB1_A, 0);
    checkOutput("t5 rw on reset", RB1_RW, 1);
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    checkOutput("t5 no resume sen", sen, 1);
    checkOutput("t5 no resume busy", busy, 0);
    checkOutput("t5 partial len", lens[lens.size() - 1], 11);
    S2_done = 1'b0;
    applyStimulus();
    waitDone(300, lat);
    checkOutput("t5 latency", lat, 203);
    tick(); tick();
    verifyFrames("t5");

    $display("[TB] S2_done already high");
    auto_s2 = 1'b0; S2_done = 1'b1;
    applyStimulus();
    waitDone(300, lat);
    checkOutput("t6 latency", lat, 203);
    tick(); tick();
    checkOutput("t6 done count", done_count - done_base, 1);
    checkOutput("t6 frame count", frames.size() - base, 8);
    checkOutput("t6 busy after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
